segment_led_axil_slave: RTL

AXI4-Lite slave register block that answers the master VIP / PS register accesses for the SegmentLed IP and drives a 4-digit multiplexed 7-segment display. It holds four fully read/write 32-bit registers, which read back exactly what was written, and scans the hex digits onto common-anode segment and anode outputs at a programmable refresh rate.

---
 rtl/segment_led_pkg.sv | 29 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/segment_led_axil_slave.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/segment_led_pkg.sv
// Shared constants for the SegmentLed AXI4-Lite register block: register map,
// response codes and the hex-to-segment pattern table.
package segment_led_pkg;

  localparam logic [3:0] ADDR_VALUE    = 4'h0;
  localparam logic [3:0] ADDR_MASK     = 4'h4;
  localparam logic [3:0] ADDR_CTRL     = 4'h8;
  localparam logic [3:0] ADDR_PRESCALE = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Active-high segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_decode
  import segment_led_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_PATTERN[nibble];

endmodule

// File: rtl/segment_led_axil_slave.sv
// AXI4-Lite slave with four R/W registers driving a 4-digit multiplexed
// common-anode 7-segment display.
module segment_led_axil_slave
  import segment_led_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_DIGITS         = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [6:0]                      seg_n,
  output logic                            dp_n,
  output logic [NUM_DIGITS-1:0]           an_n
);

  localparam logic [1:0] SEL_VALUE    = ADDR_VALUE[3:2];
  localparam logic [1:0] SEL_MASK     = ADDR_MASK[3:2];
  localparam logic [1:0] SEL_CTRL     = ADDR_CTRL[3:2];
  localparam logic [1:0] SEL_PRESCALE = ADDR_PRESCALE[3:2];

  logic        clk;
  logic        rst_n;
  logic        ready_en;
  logic        aw_full, w_full;
  logic [3:0]  aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q, rvalid_q;
  logic [31:0] rdata_q, rd_mux;
  logic [31:0] reg_value, reg_mask, reg_ctrl, reg_prescale;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [15:0] scan_cnt;
  logic [1:0]  digit_idx;
  logic [3:0]  nibble;
  logic [6:0]  seg_on;
  logic [3:0]  digit_en, digit_dp, an_next;
  logic [6:0]  seg_n_q;
  logic        dp_n_q;
  logic [3:0]  an_n_q;
  logic        unused_bits;

  assign clk   = s00_axi_aclk;
  assign rst_n = s00_axi_aresetn;

  // Handshakes: a beat transfers on the rising edge where valid & ready are
  // both high; valid, once raised, is held with stable payload until then.
  // ready_en is a flop cleared by reset so every ready drops asynchronously
  // and returns on the first edge after reset release.
  assign s00_axi_awready = ready_en & ~aw_full & ~bvalid_q;
  assign s00_axi_wready  = ready_en & ~w_full & ~bvalid_q;
  assign s00_axi_arready = ready_en & ~rvalid_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_rresp   = RESP_OKAY;
  assign s00_axi_rdata   = rdata_q;

  assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
  assign w_hs   = s00_axi_wvalid & s00_axi_wready;
  assign b_hs   = bvalid_q & s00_axi_bready;
  assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
  assign r_hs   = rvalid_q & s00_axi_rready;
  assign commit = aw_full & w_full & ~bvalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (b_hs) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_full   <= 1'b1;
          aw_addr_q <= s00_axi_awaddr;
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= s00_axi_wdata;
          w_strb_q <= s00_axi_wstrb;
        end
        if (commit) bvalid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_value    <= '0;
      reg_mask     <= '0;
      reg_ctrl     <= '0;
      reg_prescale <= '0;
    end else if (commit) begin
      case (aw_addr_q[3:2])
        SEL_VALUE:    reg_value    <= apply_wstrb(reg_value, w_data_q, w_strb_q);
        SEL_MASK:     reg_mask     <= apply_wstrb(reg_mask, w_data_q, w_strb_q);
        SEL_CTRL:     reg_ctrl     <= apply_wstrb(reg_ctrl, w_data_q, w_strb_q);
        SEL_PRESCALE: reg_prescale <= apply_wstrb(reg_prescale, w_data_q, w_strb_q);
        default:      ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s00_axi_araddr[3:2])
      SEL_VALUE:    rd_mux = reg_value;
      SEL_MASK:     rd_mux = reg_mask;
      SEL_CTRL:     rd_mux = reg_ctrl;
      SEL_PRESCALE: rd_mux = reg_prescale;
      default:      rd_mux = '0;
    endcase
  end

  // Register reads sample pre-commit values when both land on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

  // >= rather than == so a prescale lowered below the count clears next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt >= reg_prescale[15:0]) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  assign nibble   = reg_value[{digit_idx, 2'b00} +: 4];
  assign digit_en = reg_mask[3:0];
  assign digit_dp = reg_mask[7:4];

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .seg    (seg_on)
  );

  always_comb begin
    an_next            = 4'hF;
    an_next[digit_idx] = ~(reg_ctrl[0] & digit_en[digit_idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n_q <= 7'h7F;
      dp_n_q  <= 1'b1;
      an_n_q  <= 4'hF;
    end else begin
      seg_n_q <= ~seg_on;
      dp_n_q  <= ~digit_dp[digit_idx];
      an_n_q  <= an_next;
    end
  end

  assign seg_n = seg_n_q;
  assign dp_n  = dp_n_q;
  assign an_n  = an_n_q;

  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_araddr[1:0],
                         aw_addr_q[1:0], reg_ctrl[31:1], reg_prescale[31:16],
                         reg_mask[31:8]};

endmodule
